// File: rtl/grf_mp.sv
// grf_mp: multi-port general register file for the D stage.
// Two write ports (W0 main writeback, W1 late multi-cycle writeback) with
// same-cycle write-through to every read port, plus a per-register busy
// scoreboard and a registered count of busy registers for the stall logic.
module grf_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NRD    = 2,
    parameter int unsigned TRACE  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD*ADDR_W-1:0]    RA,
    output logic [NRD*DATA_W-1:0]    RD,
    output logic [NRD-1:0]           RBUSY,
    input  logic                     WE0,
    input  logic [ADDR_W-1:0]        WA0,
    input  logic [DATA_W-1:0]        WD0,
    input  logic [31:0]              PC0,
    input  logic                     WE1,
    input  logic [ADDR_W-1:0]        WA1,
    input  logic [DATA_W-1:0]        WD1,
    input  logic [31:0]              PC1,
    input  logic                     SET_EN,
    input  logic [ADDR_W-1:0]        SET_A,
    output logic [ADDR_W:0]          BUSY_CNT
);

    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              we0_c;
    logic              we1_c;
    logic              set_c;
    logic              inc_c;
    logic              dec_c;

    // Writes and busy marks aimed at $0 are dropped.
    assign we0_c = WE0 && (WA0 != '0);
    assign we1_c = WE1 && (WA1 != '0);
    assign set_c = SET_EN && (SET_A != '0);

    // Busy next-state: W1 commit clears, SET_EN sets (set applied last so it wins).
    always_comb begin
        busy_d = busy_q;
        inc_c  = 1'b0;
        dec_c  = 1'b0;
        if (we1_c) begin
            busy_d[WA1] = 1'b0;
        end
        if (set_c) begin
            busy_d[SET_A] = 1'b1;
        end
        inc_c = set_c && !busy_q[SET_A];
        dec_c = we1_c && busy_q[WA1] && !(set_c && (SET_A == WA1));
        cnt_d = cnt_q + CNT_W'(inc_c) - CNT_W'(dec_c);
    end

    // Scoreboard and busy count registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Register array; W1 is written after W0 so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            if (we0_c) begin
                regs_q[WA0] <= WD0;
            end
            if (we1_c) begin
                regs_q[WA1] <= WD1;
            end
        end
    end

    // Simulation trace of committed writes, W0 before W1; a W0 write shadowed by W1 is not shown.
    always @(posedge clk) begin
        if ((TRACE != 0) && reset) begin
            if (we0_c && !(we1_c && (WA1 == WA0))) begin
                $display("%d@%h: $%d <= %h", $time, PC0, WA0, WD0);
            end
            if (we1_c) begin
                $display("%d@%h: $%d <= %h", $time, PC1, WA1, WD1);
            end
        end
    end

    assign BUSY_CNT = cnt_q;

    // Read ports: W1 bypass, then W0 bypass, then stored value; busy hidden while W1 delivers.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;
        assign ra   = RA[i*ADDR_W +: ADDR_W];
        assign hit1 = WE1 && (WA1 == ra) && (ra != '0);
        assign hit0 = WE0 && (WA0 == ra) && (ra != '0);
        assign RD[i*DATA_W +: DATA_W] = hit1 ? WD1 : (hit0 ? WD0 : regs_q[ra]);
        assign RBUSY[i] = (ra != '0) && busy_q[ra] && !(WE1 && (WA1 == ra));
    end

endmodule

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed plus random stimulus against a behavioural register file model;
// expected responses queue up per cycle and a monitor compares them at the falling edge.
module tb_grf_mp;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NR   = 2;
    localparam int unsigned NREG = 1 << AW;

    logic               clk = 1'b0;
    logic               reset;
    logic [NR*AW-1:0]   RA;
    logic [NR*DW-1:0]   RD;
    logic [NR-1:0]      RBUSY;
    logic               WE0, WE1, SET_EN;
    logic [AW-1:0]      WA0, WA1, SET_A;
    logic [DW-1:0]      WD0, WD1;
    logic [31:0]        PC0, PC1;
    logic [AW:0]        BUSY_CNT;

    grf_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .TRACE(1)) dut (
        .clk(clk), .reset(reset), .RA(RA), .RD(RD), .RBUSY(RBUSY),
        .WE0(WE0), .WA0(WA0), .WD0(WD0), .PC0(PC0),
        .WE1(WE1), .WA1(WA1), .WD1(WD1), .PC1(PC1),
        .SET_EN(SET_EN), .SET_A(SET_A), .BUSY_CNT(BUSY_CNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          we0;
        int unsigned wa0;
        logic [31:0] wd0;
        logic [31:0] pc0;
        bit          we1;
        int unsigned wa1;
        logic [31:0] wd1;
        logic [31:0] pc1;
        bit          set_en;
        int unsigned set_a;
        int unsigned ra [NR];
    } stim_t;

    typedef struct {
        int          cyc;
        logic [31:0] rd [NR];
        bit          rbusy [NR];
        int unsigned cnt;
    } exp_t;

    // Behavioural model: plain arrays of register values and busy flags.
    logic [31:0] m_mem  [NREG];
    bit          m_busy [NREG];
    exp_t        q [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    function automatic int unsigned busy_count();
        int unsigned n = 0;
        for (int r = 0; r < int'(NREG); r++) if (m_busy[r]) n++;
        return n;
    endfunction

    function automatic stim_t idle(int unsigned ra0, int unsigned ra1);
        stim_t s;
        s.rst_n = 1'b1; s.we0 = 1'b0; s.wa0 = 0; s.wd0 = '0; s.pc0 = '0;
        s.we1 = 1'b0; s.wa1 = 0; s.wd1 = '0; s.pc1 = '0;
        s.set_en = 1'b0; s.set_a = 0;
        s.ra[0] = ra0; s.ra[1] = ra1;
        return s;
    endfunction

    task automatic apply(input stim_t s, input bit check);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = s.rst_n;
        WE0    = s.we0;  WA0 = AW'(s.wa0); WD0 = s.wd0; PC0 = s.pc0;
        WE1    = s.we1;  WA1 = AW'(s.wa1); WD1 = s.wd1; PC1 = s.pc1;
        SET_EN = s.set_en; SET_A = AW'(s.set_a);
        for (int i = 0; i < int'(NR); i++) RA[i*AW +: AW] = AW'(s.ra[i]);
        cyc++;
        if (check) begin
            e.cyc = cyc;
            for (int i = 0; i < int'(NR); i++) begin
                if (s.ra[i] != 0 && s.we1 && s.wa1 == s.ra[i])      e.rd[i] = s.wd1;
                else if (s.ra[i] != 0 && s.we0 && s.wa0 == s.ra[i]) e.rd[i] = s.wd0;
                else if (s.ra[i] == 0)                              e.rd[i] = '0;
                else                                                e.rd[i] = m_mem[s.ra[i]];
                e.rbusy[i] = (s.ra[i] != 0) && m_busy[s.ra[i]] && !(s.we1 && s.wa1 == s.ra[i]);
            end
            e.cnt = busy_count();
            q.push_back(e);
        end
        // Model state after this edge.
        if (!s.rst_n) begin
            for (int r = 0; r < int'(NREG); r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
        end else begin
            if (s.we0 && s.wa0 != 0) m_mem[s.wa0] = s.wd0;
            if (s.we1 && s.wa1 != 0) begin m_mem[s.wa1] = s.wd1; m_busy[s.wa1] = 1'b0; end
            if (s.set_en && s.set_a != 0) m_busy[s.set_a] = 1'b1;
        end
    endtask

    // Monitor: compares the oldest expected response against the DUT each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < int'(NR); i++) begin
                    tests++;
                    if (RD[i*DW +: DW] !== e.rd[i]) begin
                        fails++;
                        $display("FAIL rd%0d cyc %0d: got %h expected %h", i, e.cyc, RD[i*DW +: DW], e.rd[i]);
                    end
                    tests++;
                    if (RBUSY[i] !== e.rbusy[i]) begin
                        fails++;
                        $display("FAIL rbusy%0d cyc %0d: got %b expected %b", i, e.cyc, RBUSY[i], e.rbusy[i]);
                    end
                end
                tests++;
                if (BUSY_CNT !== (AW+1)'(e.cnt)) begin
                    fails++;
                    $display("FAIL busy_cnt cyc %0d: got %0d expected %0d", e.cyc, BUSY_CNT, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b0; WE0 = 1'b0; WE1 = 1'b0; SET_EN = 1'b0;
        WA0 = '0; WA1 = '0; SET_A = '0; WD0 = '0; WD1 = '0; PC0 = '0; PC1 = '0; RA = '0;
        for (int r = 0; r < int'(NREG); r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end

        // Reset for two cycles, then a write to $0 that must vanish.
        s = idle(0, 0); s.rst_n = 1'b0;
        apply(s, 1'b0);
        apply(s, 1'b0);
        s = idle(0, 0); s.we0 = 1'b1; s.wa0 = 0; s.wd0 = 32'hDEADBEEF; s.pc0 = 32'h2FFC;
        apply(s, 1'b1);
        apply(idle(0, 0), 1'b1);

        // Basic W0 write with bypass.
        s = idle(5, 0); s.we0 = 1'b1; s.wa0 = 5; s.wd0 = 32'h12345678; s.pc0 = 32'h3000;
        apply(s, 1'b1);
        apply(idle(5, 5), 1'b1);

        // Dual write to the same register: W1 wins.
        s = idle(7, 5); s.we0 = 1'b1; s.wa0 = 7; s.wd0 = 32'h1; s.pc0 = 32'h3004;
        s.we1 = 1'b1; s.wa1 = 7; s.wd1 = 32'h2; s.pc1 = 32'h3008;
        apply(s, 1'b1);
        apply(idle(7, 0), 1'b1);

        // Scoreboard lifecycle on $9.
        s = idle(0, 9); s.set_en = 1'b1; s.set_a = 9;
        apply(s, 1'b1);
        apply(idle(0, 9), 1'b1);
        s = idle(9, 9); s.we1 = 1'b1; s.wa1 = 9; s.wd1 = 32'hAA; s.pc1 = 32'h300C;
        apply(s, 1'b1);
        apply(idle(0, 9), 1'b1);

        // Set/clear race on $3.
        s = idle(3, 0); s.set_en = 1'b1; s.set_a = 3;
        apply(s, 1'b1);
        apply(idle(3, 3), 1'b1);
        s = idle(3, 3); s.set_en = 1'b1; s.set_a = 3; s.we1 = 1'b1; s.wa1 = 3; s.wd1 = 32'h55; s.pc1 = 32'h3010;
        apply(s, 1'b1);
        apply(idle(3, 0), 1'b1);

        // Saturate the scoreboard, then reset mid-operation.
        for (int a = 0; a < int'(NREG); a++) begin
            s = idle(a, 3); s.set_en = 1'b1; s.set_a = a;
            apply(s, 1'b1);
        end
        apply(idle(31, 1), 1'b1);
        s = idle(31, 3); s.rst_n = 1'b0; s.set_en = 1'b1; s.set_a = 4;
        s.we0 = 1'b1; s.wa0 = 6; s.wd0 = 32'h77;
        apply(s, 1'b1);
        apply(idle(4, 6), 1'b1);
        apply(idle(31, 5), 1'b1);

        // Random traffic, biased to a few addresses so collisions happen.
        for (int n = 0; n < 1500; n++) begin
            s = idle(0, 0);
            s.rst_n  = ($urandom_range(0, 99) != 0);
            s.we0    = ($urandom_range(0, 1) == 1);
            s.we1    = ($urandom_range(0, 2) == 0);
            s.set_en = ($urandom_range(0, 2) == 0);
            s.wa0    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(0, 31);
            s.wa1    = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(0, 31);
            s.set_a  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(0, 31);
            s.wd0    = $urandom; s.wd1 = $urandom;
            s.pc0    = 32'h4000 + 32'(n * 8); s.pc1 = 32'h4004 + 32'(n * 8);
            for (int i = 0; i < int'(NR); i++)
                s.ra[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : $urandom_range(0, 31);
            apply(s, 1'b1);
        end

        // Drain: every queued expectation must have been consumed.
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
